// File: rtl/rgb_fade_sequencer.sv
// SMOOTH-mode colour walker: ramps one LSB per tick through a six-colour palette, then holds.
// Define RGB_FADE_SYNC_ALIGN_EN to update the colour outputs only on the PWM new-cycle pulse.
module rgb_fade_sequencer #(
    parameter int TICK_DIV   = 390_625,
    parameter int HOLD_STEPS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sync,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       busy,
    output logic [2:0] idx_o,
    output logic       wrap_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS);
    localparam logic [23:0]   RESET_RGB = 24'hFF0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [23:0]   cur_q, cur_d;
    logic [2:0]    idx_q, idx_d;
    logic          wrap_q, wrap_d;
    logic          busy_q, busy_d;
    logic [23:0]   out_q;
    logic [23:0]   tgt;
    logic [23:0]   stepped;
    logic [2:0]    idx_next;
    logic          tick;
    logic          load_out;

    function automatic logic [23:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    palette = 24'hFF0000;
            3'd1:    palette = 24'hFFFF00;
            3'd2:    palette = 24'h00FF00;
            3'd3:    palette = 24'h00FFFF;
            3'd4:    palette = 24'h0000FF;
            3'd5:    palette = 24'hFF00FF;
            default: palette = 24'hFF0000;
        endcase
    endfunction

    function automatic logic [7:0] step_ch(input logic [7:0] c, input logic [7:0] t);
        if (c < t)      step_ch = c + 8'd1;
        else if (c > t) step_ch = c - 8'd1;
        else            step_ch = c;
    endfunction

    assign idx_next = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    assign tgt      = palette(idx_next);
    assign tick     = (state_q != S_IDLE) && (pre_q == PRE_LAST);
    assign stepped  = {step_ch(cur_q[23:16], tgt[23:16]),
                       step_ch(cur_q[15:8],  tgt[15:8]),
                       step_ch(cur_q[7:0],   tgt[7:0])};

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        hold_d  = hold_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        if (!en) begin
            // Disable beats a coincident tick: nothing steps, position is kept.
            state_d = S_IDLE;
            pre_d   = '0;
            hold_d  = '0;
        end else begin
            if (state_q != S_IDLE) begin
                pre_d = tick ? '0 : pre_q + PW'(1);
            end
            case (state_q)
                S_IDLE: state_d = S_RAMP;
                S_RAMP: begin
                    if (tick) begin
                        cur_d = stepped;
                        if (stepped == tgt) begin
                            idx_d   = idx_next;
                            hold_d  = '0;
                            state_d = S_HOLD;
                            wrap_d  = (idx_next == 3'd0);
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        hold_d = hold_q + HW'(1);
                        if (hold_q + HW'(1) == HOLD_LAST) begin
                            state_d = S_RAMP;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_RAMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            hold_q  <= '0;
            cur_q   <= RESET_RGB;
            idx_q   <= 3'd0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

`ifdef RGB_FADE_SYNC_ALIGN_EN
    assign load_out = sync;
`else
    // Outputs track cur every cycle; sync has no effect in this build.
    assign load_out = sync | 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= RESET_RGB;
        end else if (load_out) begin
            out_q <= cur_q;
        end
    end

    assign red_o   = out_q[23:16];
    assign green_o = out_q[15:8];
    assign blue_o  = out_q[7:0];
    assign busy    = busy_q;
    assign idx_o   = idx_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer: expected colour/index trajectories are queued from
// palette arithmetic, a monitor pops them on every observed output change.
module tb_rgb_fade_sequencer;

    localparam int TD = 4;
    localparam int HS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [7:0] red, green, blue;
    logic       busy;
    logic [2:0] idx;
    logic       wrap;

    rgb_fade_sequencer #(.TICK_DIV(TD), .HOLD_STEPS(HS)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .red_o   (red),
        .green_o (green),
        .blue_o  (blue),
        .busy    (busy),
        .idx_o   (idx),
        .wrap_o  (wrap)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [23:0] col_q[$];
    logic [2:0]  idx_q[$];
    bit          mon_en = 1'b0;
    bit          sync_manual = 1'b0;
    int          wrap_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [23:0] pal(input int i);
        case (i)
            0:       pal = 24'hFF0000;
            1:       pal = 24'hFFFF00;
            2:       pal = 24'h00FF00;
            3:       pal = 24'h00FFFF;
            4:       pal = 24'h0000FF;
            default: pal = 24'hFF00FF;
        endcase
    endfunction

    // Colours seen on the way from palette[from] to palette[from+1], then the new index.
    task automatic push_segment(input int from);
        logic [23:0] a, b, c;
        int to, av, bv, v;
        to = (from + 1) % 6;
        a = pal(from);
        b = pal(to);
        for (int k = 1; k <= 255; k++) begin
            for (int ch = 0; ch < 3; ch++) begin
                av = int'(a[ch*8 +: 8]);
                bv = int'(b[ch*8 +: 8]);
                v = av + ((bv > av) ? k : ((bv < av) ? -k : 0));
                c[ch*8 +: 8] = 8'(v);
            end
            col_q.push_back(c);
        end
        idx_q.push_back(3'(to));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0] prev_c, now_c, e;
        logic [2:0]  prev_i, ei;
        prev_c = 24'hFF0000;
        prev_i = 3'd0;
        forever begin
            @(negedge clk);
            now_c = {red, green, blue};
            if (wrap === 1'b1) wrap_cnt++;
            if (mon_en) begin
                if (now_c !== prev_c) begin
                    if (col_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL colour_unexpected: got %06h with nothing expected", now_c);
                    end else begin
                        e = col_q.pop_front();
                        check("colour_seq", 32'(now_c), 32'(e));
                    end
                end
                if (idx !== prev_i) begin
                    if (idx_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL idx_unexpected: got %0d with nothing expected", idx);
                    end else begin
                        ei = idx_q.pop_front();
                        check("idx_seq", 32'(idx), 32'(ei));
                    end
                end
            end
            prev_c = now_c;
            prev_i = idx;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!sync_manual) begin
`ifdef RGB_FADE_SYNC_ALIGN_EN
                sync = 1'b1;
`else
                sync = 1'($urandom_range(0, 1));
`endif
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, bad, hi, lo, guard;
        bit b1, done;
        logic [23:0] snap;

        reset_dut();
        @(negedge clk);
        check("reset_state", 32'({red, green, blue, busy, idx, wrap}), 32'({24'hFF0000, 1'b0, 3'd0, 1'b0}));
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({red, green, blue, busy, idx, wrap} !== {24'hFF0000, 1'b0, 3'd0, 1'b0}) bad++;
        end
        check("idle_stable_100", 32'(bad), 32'd0);

        for (int s = 0; s < 6; s++) push_segment(s);
        mon_en = 1'b1;
        en = 1'b1;
        cnt = 0;
        b1 = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) b1 = busy;
        end while (green == 8'h00 && cnt < 50);
        check("first_step_latency", 32'(cnt), 32'(TD + 2));
        check("busy_on_ramp", 32'(b1), 32'd1);
        cnt = 0;
        while (green != 8'h02 && cnt < 50) begin @(negedge clk); cnt++; end
        check("step_period", 32'(cnt), 32'(TD));

        cnt = 0;
        while (idx != 3'd1 && cnt < 3000) begin @(negedge clk); cnt++; end
        check("reach_idx1", 32'(idx), 32'd1);
        check("busy_low_in_hold", 32'(busy), 32'd0);
        cnt = 0;
        while (busy !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("colour_at_hold", 32'({red, green, blue}), 32'h00FFFF00);
        end
        check("hold_length", 32'(cnt), 32'(TD * HS));

        cnt = 0;
        while (wrap !== 1'b1 && cnt < 8000) begin @(negedge clk); cnt++; end
        check("wrap_seen", 32'(wrap), 32'd1);
        check("idx_at_wrap", 32'(idx), 32'd0);
        push_segment(0);
        push_segment(1);
        @(negedge clk);
        check("wrap_width", 32'(wrap), 32'd0);
        check("colour_at_wrap", 32'({red, green, blue}), 32'h00FF0000);
        check("wrap_count_lap", 32'(wrap_cnt), 32'd1);

        done = 1'b0;
        guard = 0;
        while (!done && guard < 200) begin
            guard++;
            en = 1'b1;
            hi = $urandom_range(1, 300);
            for (int i = 0; i < hi; i++) begin
                @(negedge clk);
                if (idx == 3'd2) begin done = 1'b1; break; end
            end
            en = 1'b0;
            if (!done) begin
                lo = $urandom_range(3, 40);
                repeat (2) @(negedge clk);
                snap = {red, green, blue};
                repeat (lo - 2) @(negedge clk);
                check("freeze_when_disabled", 32'({busy, red, green, blue}), 32'({1'b0, snap}));
            end
        end
        en = 1'b0;
        check("reach_idx2", 32'(idx), 32'd2);
        repeat (4) @(negedge clk);
        check("queue_drained_random", 32'(col_q.size() + idx_q.size()), 32'd0);

        push_segment(2);
        en = 1'b1;
        cnt = 0;
        while (blue != 8'h80 && cnt < 3000) begin @(negedge clk); cnt++; end
        en = 1'b0;
        check("blue_reached_80", 32'(blue), 32'h80);
        repeat (2000) @(negedge clk);
        check("hold_80_2000", 32'({busy, blue}), 32'({1'b0, 8'h80}));
        en = 1'b1;
        cnt = 0;
        while (idx != 3'd3 && cnt < 1000) begin @(negedge clk); cnt++; end
        check("resume_to_idx3_cycles", 32'(cnt), 32'(1 + 127 * TD));
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("queue_drained_resume", 32'(col_q.size() + idx_q.size()), 32'd0);
        check("wrap_count_total", 32'(wrap_cnt), 32'd1);

`ifdef RGB_FADE_SYNC_ALIGN_EN
        mon_en = 1'b0;
        sync_manual = 1'b1;
        sync = 1'b0;
        reset_dut();
        en = 1'b1;
        repeat (41) @(negedge clk);
        check("sync_low_hold", 32'({red, green, blue}), 32'h00FF0000);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check("sync_pulse_load", 32'({red, green, blue}), 32'h00FF0A00);
        repeat (8) @(negedge clk);
        check("sync_hold_after_pulse", 32'({red, green, blue}), 32'h00FF0A00);
        en = 1'b0;
        sync_manual = 1'b0;
`endif

        mon_en = 1'b0;
        reset_dut();
        col_q.delete();
        idx_q.delete();
        push_segment(0);
        mon_en = 1'b1;
        en = 1'b1;
        cnt = 0;
        while (green != 8'h40 && cnt < 1000) begin @(negedge clk); cnt++; end
        check("green_reached_40", 32'(green), 32'h40);
        mon_en = 1'b0;
        #1 rst = 1'b1;
        #1 check("async_reset", 32'({red, green, blue, busy, idx, wrap}), 32'({24'hFF0000, 1'b0, 3'd0, 1'b0}));
        @(negedge clk);
        col_q.delete();
        idx_q.delete();
        push_segment(0);
        rst = 1'b0;
        mon_en = 1'b1;
        cnt = 0;
        while (green == 8'h00 && cnt < 50) begin @(negedge clk); cnt++; end
        check("restart_latency", 32'(cnt), 32'(TD + 2));
        check("restart_green", 32'(green), 32'h01);
        repeat (20) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
